simmem_delay_releaser: RTL

// Upstream stage of the response linked-list bank. Holds one slot per outstanding request,

---
 rtl/simmem_pkg.sv | 22 ++
 rtl/simmem_delay_slot.sv | 45 ++++
 rtl/simmem_delay_releaser.sv | 133 +++++++++++++
 3 files changed

// File: rtl/simmem_pkg.sv
// Shared constants and types for the simulated-memory response path.
package simmem_pkg;

    localparam int IDWidth      = 4;
    localparam int NumSlots     = 8;
    localparam int DelayWidth   = 6;
    localparam int NumIds       = 2 ** IDWidth;
    localparam int SlotIdxWidth = $clog2(NumSlots);

    // One outstanding request: its ID, remaining delay and its position
    // among the pending requests of the same ID (0 = oldest).
    typedef struct packed {
        logic                    valid;
        logic [IDWidth-1:0]      id;
        logic [DelayWidth-1:0]   cnt;
        logic [SlotIdxWidth-1:0] rank;
    } delay_slot_t;

    // Per-ID release enables, shared with simmem_linkedlist_bank.
    typedef logic [NumIds-1:0] release_vec_t;

endpackage

// File: rtl/simmem_delay_slot.sv
// One delay slot: holds a request's ID, counts its delay down to zero and
// tracks its in-order rank among pending requests of the same ID.
module simmem_delay_slot
    import simmem_pkg::*;
(
    input  logic                    clk_i,
    input  logic                    rst_ni,
    input  logic                    load_i,
    input  logic                    free_i,
    input  logic                    rank_dec_i,
    input  logic [IDWidth-1:0]      load_id_i,
    input  logic [DelayWidth-1:0]   load_cnt_i,
    input  logic [SlotIdxWidth-1:0] load_rank_i,
    output delay_slot_t             slot_o,
    output logic                    expired_head_o
);

    delay_slot_t r_slot;

    // Slot register: free wins (it only targets valid slots, load only
    // targets invalid ones); a loaded slot skips its first decrement.
    always_ff @(posedge clk_i) begin
        if (!rst_ni) begin
            r_slot <= '0;
        end else if (free_i) begin
            r_slot <= '0;
        end else if (load_i) begin
            r_slot.valid <= 1'b1;
            r_slot.id    <= load_id_i;
            r_slot.cnt   <= load_cnt_i;
            r_slot.rank  <= load_rank_i;
        end else if (r_slot.valid) begin
            if (r_slot.cnt != '0) begin
                r_slot.cnt <= r_slot.cnt - 1'b1;
            end
            if (rank_dec_i && (r_slot.rank != '0)) begin
                r_slot.rank <= r_slot.rank - 1'b1;
            end
        end
    end

    assign slot_o         = r_slot;
    assign expired_head_o = r_slot.valid && (r_slot.rank == '0) && (r_slot.cnt == '0);

endmodule

// File: rtl/simmem_delay_releaser.sv
// Delay releaser: tracks outstanding requests in NumSlots delay slots and
// raises a per-ID release enable once the oldest request of that ID has
// waited out its programmed delay.
//
// Handshake: a request is accepted on a rising edge where req_valid_i and
// req_ready_o are both high; req_ready_o depends only on registered slot
// state. rsp_done_i is a single-cycle event reporting that the bank has
// released one response of rsp_done_id_i.
module simmem_delay_releaser
    import simmem_pkg::*;
(
    input  logic                  clk_i,
    input  logic                  rst_ni,
    input  logic                  req_valid_i,
    output logic                  req_ready_o,
    input  logic [IDWidth-1:0]    req_id_i,
    input  logic [DelayWidth-1:0] req_delay_i,
    output release_vec_t          release_en_o,
    input  logic                  rsp_done_i,
    input  logic [IDWidth-1:0]    rsp_done_id_i,
    output logic                  err_o
);

    delay_slot_t               w_slots [NumSlots];
    logic [NumSlots-1:0]       w_expired_head;
    logic [NumSlots-1:0]       w_free_hit;
    logic [NumSlots-1:0]       w_free;
    logic [NumSlots-1:0]       w_rank_dec;
    logic [NumSlots-1:0]       w_load;
    logic [NumSlots-1:0]       w_valid;
    logic                      w_free_fire;
    logic                      w_accept;
    logic                      w_found;
    logic [SlotIdxWidth-1:0]   w_load_idx;
    logic [SlotIdxWidth:0]     w_same_cnt;
    logic [SlotIdxWidth:0]     w_rank_full;
    logic [SlotIdxWidth-1:0]   w_load_rank;
    logic                      r_err;

    // Release matching: find the expired head of the completed ID and the
    // younger same-ID slots whose rank moves up by one.
    always_comb begin
        w_free_hit = '0;
        w_rank_dec = '0;
        w_valid    = '0;
        for (int i = 0; i < NumSlots; i++) begin
            w_valid[i]    = w_slots[i].valid;
            w_free_hit[i] = w_slots[i].valid && (w_slots[i].id == rsp_done_id_i)
                            && (w_slots[i].rank == '0) && (w_slots[i].cnt == '0);
        end
        w_free_fire = rsp_done_i && (|w_free_hit);
        for (int i = 0; i < NumSlots; i++) begin
            w_rank_dec[i] = w_free_fire && w_slots[i].valid
                            && (w_slots[i].id == rsp_done_id_i) && !w_free_hit[i];
        end
        w_free = w_free_fire ? w_free_hit : '0;
    end

    // Lowest-index free slot receives the next accepted request.
    always_comb begin
        w_found    = 1'b0;
        w_load_idx = '0;
        for (int i = 0; i < NumSlots; i++) begin
            if (!w_slots[i].valid && !w_found) begin
                w_found    = 1'b1;
                w_load_idx = SlotIdxWidth'(i);
            end
        end
    end

    // New entry's rank: older same-ID entries still pending after this edge.
    always_comb begin
        w_same_cnt = '0;
        for (int i = 0; i < NumSlots; i++) begin
            if (w_slots[i].valid && (w_slots[i].id == req_id_i)) begin
                w_same_cnt = w_same_cnt + (SlotIdxWidth + 1)'(1);
            end
        end
        w_rank_full = w_same_cnt;
        if (w_free_fire && (rsp_done_id_i == req_id_i)) begin
            w_rank_full = w_same_cnt - (SlotIdxWidth + 1)'(1);
        end
        w_load_rank = w_rank_full[SlotIdxWidth-1:0];
    end

    assign req_ready_o = |(~w_valid);
    assign w_accept    = req_valid_i && req_ready_o;

    // One-hot load strobe for the chosen free slot.
    always_comb begin
        w_load = '0;
        for (int i = 0; i < NumSlots; i++) begin
            w_load[i] = w_accept && (w_load_idx == SlotIdxWidth'(i));
        end
    end

    for (genvar g = 0; g < NumSlots; g++) begin : g_slot
        simmem_delay_slot u_slot (
            .clk_i          (clk_i),
            .rst_ni         (rst_ni),
            .load_i         (w_load[g]),
            .free_i         (w_free[g]),
            .rank_dec_i     (w_rank_dec[g]),
            .load_id_i      (req_id_i),
            .load_cnt_i     (req_delay_i),
            .load_rank_i    (w_load_rank),
            .slot_o         (w_slots[g]),
            .expired_head_o (w_expired_head[g])
        );
    end

    // Per-ID release enable: OR of the expired-head flags of that ID.
    always_comb begin
        release_en_o = '0;
        for (int i = 0; i < NumSlots; i++) begin
            if (w_expired_head[i]) begin
                release_en_o[w_slots[i].id] = 1'b1;
            end
        end
    end

    // Sticky error: a completion arrived for an ID with no expired head.
    always_ff @(posedge clk_i) begin
        if (!rst_ni) begin
            r_err <= 1'b0;
        end else if (rsp_done_i && !(|w_free_hit)) begin
            r_err <= 1'b1;
        end
    end

    assign err_o = r_err;

endmodule
